// File: rtl/wb_forward_unit_if.sv
// Bus bundle for wb_forward_unit: EX/MEM producer inputs, DOF operand path and the register
// file write port. The master side drives the pipeline inputs; the slave side is the unit.
interface wb_forward_unit_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic          ex_valid;
  logic          ex_rw;
  logic [AW-1:0] ex_da;
  logic [DW-1:0] ex_result;
  logic          ex_is_load;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] dof_aa;
  logic [AW-1:0] dof_ba;
  logic [DW-1:0] dof_a_rf;
  logic [DW-1:0] dof_b_rf;
  logic [DW-1:0] dof_a;
  logic [DW-1:0] dof_b;
  logic          stall;
  logic [AW-1:0] rf_d_addr;
  logic [DW-1:0] rf_d_data;
  logic          rf_d_write;
  logic [15:0]   stall_cnt;

  modport master (
    output ex_valid, ex_rw, ex_da, ex_result, ex_is_load, mem_rdata,
    output dof_aa, dof_ba, dof_a_rf, dof_b_rf,
    input  dof_a, dof_b, stall, rf_d_addr, rf_d_data, rf_d_write, stall_cnt
  );

  modport slave (
    input  ex_valid, ex_rw, ex_da, ex_result, ex_is_load, mem_rdata,
    input  dof_aa, dof_ba, dof_a_rf, dof_b_rf,
    output dof_a, dof_b, stall, rf_d_addr, rf_d_data, rf_d_write, stall_cnt
  );
endinterface

// File: rtl/wb_forward_unit.sv
// Writeback-side companion to the register file: carries results EX -> M -> W, drives the
// file write port and forwards DOF operands, raising a stall on load-use hazards.
module wb_forward_unit #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input logic              clk,
  input logic              rst_n,
  wb_forward_unit_if.slave bus
);

  // Stage M
  logic          m_valid_q;
  logic          m_rw_q;
  logic [AW-1:0] m_da_q;
  logic [DW-1:0] m_result_q;
  logic          m_is_load_q;

  // Stage W
  logic          w_valid_q;
  logic          w_rw_q;
  logic [AW-1:0] w_da_q;
  logic [DW-1:0] w_data_q;

  logic [15:0]   stall_cnt_q;
  logic [15:0]   stall_cnt_d;

  logic          ex_live;
  logic          m_live;
  logic          w_live;
  logic [DW-1:0] m_value;

  logic          hazard_a;
  logic          hazard_b;
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;

  assign ex_live = bus.ex_valid & bus.ex_rw & (bus.ex_da != '0);
  assign m_live  = m_valid_q & m_rw_q & (m_da_q != '0);
  assign w_live  = w_valid_q & w_rw_q & (w_da_q != '0);
  // A load's data only exists while it sits in M, so M forwards mem_rdata directly.
  assign m_value = m_is_load_q ? bus.mem_rdata : m_result_q;

  // Youngest producer wins; a load still in EX has no data yet and becomes a hazard.
  function automatic logic [DW:0] resolve(
    input logic [AW-1:0] addr,
    input logic [DW-1:0] rf_data,
    input logic          ex_lv,
    input logic [AW-1:0] ex_da,
    input logic          ex_ld,
    input logic [DW-1:0] ex_res,
    input logic          m_lv,
    input logic [AW-1:0] m_da,
    input logic [DW-1:0] m_val,
    input logic          w_lv,
    input logic [AW-1:0] w_da,
    input logic [DW-1:0] w_val
  );
    logic [DW:0] r;
    r = {1'b0, rf_data};
    if (addr == '0) begin
      r = '0;
    end else if (ex_lv && (ex_da == addr)) begin
      r = ex_ld ? {1'b1, {DW{1'b0}}} : {1'b0, ex_res};
    end else if (m_lv && (m_da == addr)) begin
      r = {1'b0, m_val};
    end else if (w_lv && (w_da == addr)) begin
      r = {1'b0, w_val};
    end
    return r;
  endfunction

  always_comb begin
    {hazard_a, fwd_a} = resolve(bus.dof_aa, bus.dof_a_rf,
                                ex_live, bus.ex_da, bus.ex_is_load, bus.ex_result,
                                m_live, m_da_q, m_value, w_live, w_da_q, w_data_q);
    {hazard_b, fwd_b} = resolve(bus.dof_ba, bus.dof_b_rf,
                                ex_live, bus.ex_da, bus.ex_is_load, bus.ex_result,
                                m_live, m_da_q, m_value, w_live, w_da_q, w_data_q);
  end

  assign bus.dof_a = fwd_a;
  assign bus.dof_b = fwd_b;
  assign bus.stall = hazard_a | hazard_b;

  assign bus.rf_d_addr  = w_da_q;
  assign bus.rf_d_data  = w_data_q;
  assign bus.rf_d_write = w_live;
  assign bus.stall_cnt  = stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // The pipeline is never gated by stall; upstream inserts the bubble itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q   <= 1'b0;
      m_rw_q      <= 1'b0;
      m_da_q      <= '0;
      m_result_q  <= '0;
      m_is_load_q <= 1'b0;
      w_valid_q   <= 1'b0;
      w_rw_q      <= 1'b0;
      w_da_q      <= '0;
      w_data_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      m_valid_q   <= bus.ex_valid;
      m_rw_q      <= bus.ex_rw;
      m_da_q      <= bus.ex_da;
      m_result_q  <= bus.ex_result;
      m_is_load_q <= bus.ex_is_load;
      w_valid_q   <= m_valid_q;
      w_rw_q      <= m_rw_q;
      w_da_q      <= m_da_q;
      w_data_q    <= m_value;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // R0 is hardwired; a write to it would be a forwarding-qualification bug.
  a_no_r0_write : assert property (@(posedge clk) disable iff (!rst_n)
    bus.rf_d_write |-> (bus.rf_d_addr != '0));

  a_cnt_monotonic : assert property (@(posedge clk) disable iff (!rst_n)
    ##1 (stall_cnt_q >= $past(stall_cnt_q)));

endmodule

// File: tb/tb_wb_forward_unit.sv
// Scoreboard bench for wb_forward_unit: directed scenarios plus random traffic, checked
// against an in-flight-instruction model of the forwarding rules.
module tb_wb_forward_unit;

  logic clk;
  logic rst_n;

  wb_forward_unit_if #(.DW(32), .AW(5)) bus ();

  wb_forward_unit #(.DW(32), .AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        rw;
    logic        is_load;
    logic [4:0]  da;
    logic [31:0] result;
    logic [31:0] value;
  } inst_t;

  typedef struct {
    string       tag;
    bit          chk_a;
    bit          chk_b;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [15:0] cnt;
  } exp_t;

  // flight[0] is the instruction now in M, flight[1] the one now in W.
  inst_t       flight[$];
  exp_t        exp_q[$];
  int          n_checks;
  int          n_fail;
  int unsigned cnt_model;
  logic        last_stall;

  function automatic bit live(input inst_t i);
    return i.valid && i.rw && (i.da != 5'd0);
  endfunction

  function automatic void resolve(input logic [4:0] addr, input logic [31:0] rf, input inst_t ex,
                                  input logic [31:0] mrd, output logic haz,
                                  output logic [31:0] val);
    haz = 1'b0;
    val = rf;
    if (addr == 5'd0) begin
      val = 32'd0;
      return;
    end
    if (live(ex) && ex.da == addr) begin
      if (ex.is_load) haz = 1'b1;
      else val = ex.result;
      return;
    end
    for (int k = 0; k < flight.size(); k++) begin
      if (live(flight[k]) && flight[k].da == addr) begin
        if (k == 0) val = flight[k].is_load ? mrd : flight[k].result;
        else val = flight[k].value;
        return;
      end
    end
  endfunction

  task automatic step(input string tag, input logic rst, input logic valid, input logic rw,
                      input logic is_load, input logic [4:0] da, input logic [31:0] res,
                      input logic [31:0] mrd, input logic [4:0] aa, input logic [4:0] ba,
                      input logic [31:0] arf, input logic [31:0] brf);
    inst_t ex;
    exp_t  e;
    logic  ha, hb;
    @(posedge clk);
    #1;
    rst_n          = rst;
    bus.ex_valid   = valid;
    bus.ex_rw      = rw;
    bus.ex_is_load = is_load;
    bus.ex_da      = da;
    bus.ex_result  = res;
    bus.mem_rdata  = mrd;
    bus.dof_aa     = aa;
    bus.dof_ba     = ba;
    bus.dof_a_rf   = arf;
    bus.dof_b_rf   = brf;
    if (!rst) begin
      flight.delete();
      cnt_model = 0;
    end
    ex = '{valid: valid, rw: rw, is_load: is_load, da: da, result: res, value: res};
    e.tag = tag;
    resolve(aa, arf, ex, mrd, ha, e.a);
    resolve(ba, brf, ex, mrd, hb, e.b);
    e.chk_a = !ha;
    e.chk_b = !hb;
    e.stall = ha | hb;
    e.wr    = (flight.size() == 2) && live(flight[1]);
    e.waddr = e.wr ? flight[1].da : 5'd0;
    e.wdata = e.wr ? flight[1].value : 32'd0;
    e.cnt   = cnt_model[15:0];
    exp_q.push_back(e);
    if (rst) begin
      if (flight.size() > 0) flight[0].value = flight[0].is_load ? mrd : flight[0].result;
      flight.push_front(ex);
      if (flight.size() > 2) void'(flight.pop_back());
      if (e.stall && cnt_model < 32'hFFFF) cnt_model++;
    end
    last_stall = e.stall;
  endtask

  task automatic bubble(input string tag, input logic [31:0] mrd, input logic [4:0] aa,
                        input logic [4:0] ba, input logic [31:0] arf, input logic [31:0] brf);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, mrd, aa, ba, arf, brf);
  endtask

  task automatic chk(input string nm, input string tag, input logic [31:0] act,
                     input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s/%s: got %h expected %h at %0t", tag, nm, act, want, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk_a) chk("dof_a", e.tag, bus.dof_a, e.a);
      if (e.chk_b) chk("dof_b", e.tag, bus.dof_b, e.b);
      chk("stall", e.tag, {31'd0, bus.stall}, {31'd0, e.stall});
      chk("rf_d_write", e.tag, {31'd0, bus.rf_d_write}, {31'd0, e.wr});
      if (e.wr) begin
        chk("rf_d_addr", e.tag, {27'd0, bus.rf_d_addr}, {27'd0, e.waddr});
        chk("rf_d_data", e.tag, bus.rf_d_data, e.wdata);
      end
      chk("stall_cnt", e.tag, {16'd0, bus.stall_cnt}, {16'd0, e.cnt});
    end
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cnt_model  = 0;
    last_stall = 1'b0;
    rst_n = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_rw = 1'b0; bus.ex_is_load = 1'b0; bus.ex_da = 5'd0;
    bus.ex_result = 32'd0; bus.mem_rdata = 32'd0; bus.dof_aa = 5'd0; bus.dof_ba = 5'd0;
    bus.dof_a_rf = 32'd0; bus.dof_b_rf = 32'd0;

    // Reset held with a live writer to R3, then released.
    repeat (3) step("reset", 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h33, 32'd0, 5'd1, 5'd2, 32'd0, 32'd0);
    step("rst_rel", 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h33, 32'd0, 5'd9, 5'd10, 32'h1, 32'h2);
    repeat (3) bubble("rst_wr", 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);

    // Back-to-back ALU chain on R5.
    step("chain0", 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'h11, 32'd0, 5'd5, 5'd0, 32'd0, 32'd0);
    bubble("chain1", 32'd0, 5'd5, 5'd0, 32'd0, 32'd0);
    bubble("chain2", 32'd0, 5'd5, 5'd0, 32'd0, 32'd0);
    bubble("chain3", 32'd0, 5'd5, 5'd0, 32'h11, 32'd0);

    // Load-use on R7.
    step("ld0", 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h100, 32'd0, 5'd0, 5'd7, 32'd0, 32'd0);
    bubble("ld1", 32'hCAFEBABE, 5'd0, 5'd7, 32'd0, 32'd0);
    bubble("ld2", 32'd0, 5'd7, 5'd7, 32'd0, 32'd0);

    // Priority on R4.
    step("pri0", 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'hA, 32'd0, 5'd1, 5'd1, 32'd5, 32'd5);
    step("pri1", 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'hB, 32'd0, 5'd4, 5'd4, 32'd5, 32'd5);
    step("pri2", 1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'hC, 32'd0, 5'd4, 5'd4, 32'd5, 32'd5);

    // R0 writer and a non-writer to R2.
    step("r0_0", 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'hFF, 32'd0, 5'd0, 5'd0, 32'hDEAD, 32'hBEEF);
    step("nw_0", 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'h77, 32'd0, 5'd0, 5'd2, 32'h1, 32'h1234);
    bubble("nw_1", 32'd0, 5'd2, 5'd2, 32'h1234, 32'h1234);
    bubble("nw_2", 32'd0, 5'd2, 5'd0, 32'h1234, 32'h9);
    bubble("nw_3", 32'd0, 5'd0, 5'd0, 32'h5, 32'h6);

    // Randomized traffic with occasional mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      logic v;
      v = last_stall ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      step("rand", 1'($urandom_range(0, 299) != 0), v, 1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom, $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
    end

    // Saturation: load-use hazard held for 65540 cycles.
    step("sat_rst", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < 65540; i++) begin
      step("sat", 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h40, 32'h55, 5'd7, 5'd1, 32'd0, 32'd3);
    end
    bubble("sat_end", 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
